// File: rtl/coo_aggregator.sv
// GCN aggregation over a COO edge list: acc[dst] += XW[src] for every edge.
// One edge per cycle; the XW read is synchronous, so the add lags one cycle.
module coo_aggregator #(
    parameter int NUM_OF_NODES    = 6,
    parameter int COO_NUM_OF_COLS = 6,
    parameter int WEIGHT_COLS     = 3,
    parameter int DOT_PROD_WIDTH  = 16,
    localparam int NODE_BW   = $clog2(NUM_OF_NODES),
    localparam int COO_BW    = $clog2(COO_NUM_OF_COLS),
    localparam int AGG_WIDTH = DOT_PROD_WIDTH + $clog2(COO_NUM_OF_COLS + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic [COO_BW-1:0]                   coo_address,
    input  logic [NODE_BW-1:0]                  coo_src,
    input  logic [NODE_BW-1:0]                  coo_dst,
    output logic [NODE_BW-1:0]                  fm_read_addr,
    input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] fm_read_row,
    output logic                                busy,
    output logic                                done,
    input  logic [NODE_BW-1:0]                  out_addr,
    output logic [WEIGHT_COLS*AGG_WIDTH-1:0]    out_row
);

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, DONE} state_t;

    localparam logic [NODE_BW:0]   NODES_W   = NUM_OF_NODES[NODE_BW:0];
    localparam logic [COO_BW-1:0]  LAST_EDGE = COO_BW'(COO_NUM_OF_COLS - 1);

    state_t               state;
    state_t               state_nxt;
    logic [COO_BW-1:0]    edge_idx;
    logic [NODE_BW-1:0]   dst_q;
    logic                 vld_q;
    logic                 edge_ok;
    logic [AGG_WIDTH-1:0] acc [NUM_OF_NODES][WEIGHT_COLS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = CLEAR;
            CLEAR:      state_nxt = FETCH;
            FETCH:      if (edge_idx == LAST_EDGE) state_nxt = DRAIN;
            DRAIN:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CLEAR) || (state == FETCH) || (state == DRAIN);
    assign done = (state == DONE);

    assign coo_address  = (state == FETCH) ? edge_idx : '0;
    assign fm_read_addr = (state == FETCH) ? coo_src  : '0;

    // Edges naming a node outside the graph are skipped, not wrapped.
    assign edge_ok = ({1'b0, coo_src} < NODES_W) && ({1'b0, coo_dst} < NODES_W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_idx <= '0;
            dst_q    <= '0;
            vld_q    <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    edge_idx <= '0;
                    vld_q    <= 1'b0;
                end
                FETCH: begin
                    dst_q    <= coo_dst;
                    vld_q    <= edge_ok;
                    edge_idx <= (edge_idx == LAST_EDGE) ? '0 : edge_idx + 1'b1;
                end
                DRAIN:   vld_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Single-cycle read-modify-write, so same-dst edges back to back are safe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < NUM_OF_NODES; n++)
                for (int l = 0; l < WEIGHT_COLS; l++)
                    acc[n][l] <= '0;
        end else if (state == CLEAR) begin
            for (int n = 0; n < NUM_OF_NODES; n++)
                for (int l = 0; l < WEIGHT_COLS; l++)
                    acc[n][l] <= '0;
        end else if (vld_q) begin
            for (int l = 0; l < WEIGHT_COLS; l++)
                acc[dst_q][l] <= acc[dst_q][l] +
                    AGG_WIDTH'(fm_read_row[l*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]);
        end
    end

    always_comb begin
        out_row = '0;
        if ({1'b0, out_addr} < NODES_W) begin
            for (int l = 0; l < WEIGHT_COLS; l++)
                out_row[l*AGG_WIDTH +: AGG_WIDTH] = acc[out_addr][l];
        end
    end

endmodule

// File: tb/tb_coo_aggregator.sv
// Directed bench for coo_aggregator: COO store and synchronous XW memory
// are modelled here; each scenario task checks its own expected values.
module tb_coo_aggregator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  coo_address;
    logic [2:0]  coo_src;
    logic [2:0]  coo_dst;
    logic [2:0]  fm_read_addr;
    logic [47:0] fm_read_row = '0;
    logic        busy;
    logic        done;
    logic [2:0]  out_addr = '0;
    logic [56:0] out_row;

    logic [2:0]  src_m [8];
    logic [2:0]  dst_m [8];
    logic [47:0] xw    [8];

    int errors = 0;
    int checks = 0;

    coo_aggregator dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .coo_address(coo_address),
        .coo_src(coo_src),
        .coo_dst(coo_dst),
        .fm_read_addr(fm_read_addr),
        .fm_read_row(fm_read_row),
        .busy(busy),
        .done(done),
        .out_addr(out_addr),
        .out_row(out_row)
    );

    always #5 clk = ~clk;

    assign coo_src = src_m[coo_address];
    assign coo_dst = dst_m[coo_address];

    always @(posedge clk) fm_read_row <= xw[fm_read_addr];

    function automatic logic [56:0] r3(input int a, input int b, input int c);
        return {19'(c), 19'(b), 19'(a)};
    endfunction

    function automatic logic [47:0] x3(input int a, input int b, input int c);
        return {16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic load_ring();
        for (int i = 0; i < 8; i++) begin
            src_m[i] = 3'(i);
            dst_m[i] = 3'((i + 1) % 6);
            xw[i]    = x3(i + 1, i + 1, i + 1);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: done=%b required 1", name, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if ({busy, done, coo_address, fm_read_addr} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b ca=%0d fa=%0d required 0",
                     busy, done, coo_address, fm_read_addr);
        end
        for (int r = 0; r < 6; r++) begin
            out_addr = 3'(r);
            #1;
            checks++;
            if (out_row !== '0) begin
                errors++;
                $display("FAIL reset_row%0d: got %h required 0", r, out_row);
            end
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_ring();
        logic [56:0] exp [8];
        load_ring();
        exp = '{r3(6,6,6), r3(1,1,1), r3(2,2,2), r3(3,3,3),
                r3(4,4,4), r3(5,5,5), '0, '0};
        pulse_start();
        wait_done("ring");
        for (int r = 0; r < 8; r++) begin
            out_addr = 3'(r);
            #1;
            checks++;
            if (out_row !== exp[r]) begin
                errors++;
                $display("FAIL ring_row%0d: got %h required %h", r, out_row, exp[r]);
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        load_ring();
        pulse_start();
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || coo_address !== 3'd0) begin
            errors++;
            $display("FAIL midreset_ctrl: got busy=%b done=%b ca=%0d required 0 0 0",
                     busy, done, coo_address);
        end
        for (int r = 0; r < 6; r++) begin
            out_addr = 3'(r);
            #1;
            checks++;
            if (out_row !== '0) begin
                errors++;
                $display("FAIL midreset_row%0d: got %h required 0", r, out_row);
            end
        end
        @(negedge clk) reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_fan_in();
        for (int i = 0; i < 8; i++) begin
            src_m[i] = 3'(i % 6);
            dst_m[i] = 3'd2;
            xw[i]    = 48'hFFFF_FFFF_FFFF;
        end
        pulse_start();
        wait_done("fanin");
        for (int r = 0; r < 6; r++) begin
            out_addr = 3'(r);
            #1;
            checks++;
            if (out_row !== ((r == 2) ? r3(393210, 393210, 393210) : 57'd0)) begin
                errors++;
                $display("FAIL fanin_row%0d: got %h", r, out_row);
            end
        end
    endtask

    task automatic test_invalid_edge();
        logic [56:0] exp [8];
        load_ring();
        src_m[3] = 3'd6;
        xw[6] = x3(7, 7, 7);
        xw[7] = x3(9, 9, 9);
        exp = '{r3(6,6,6), r3(1,1,1), r3(2,2,2), r3(3,3,3),
                '0, r3(5,5,5), '0, '0};
        pulse_start();
        wait_done("invalid");
        repeat (3) @(negedge clk);
        for (int r = 0; r < 6; r++) begin
            out_addr = 3'(r);
            #1;
            checks++;
            if (out_row !== exp[r]) begin
                errors++;
                $display("FAIL invalid_row%0d: got %h required %h", r, out_row, exp[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [56:0] exp [8];
        for (int i = 0; i < 8; i++) xw[i] = x3(i + 1, 2 * (i + 1), 3 * (i + 1));
        src_m = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0};
        dst_m = '{3'd1, 3'd1, 3'd1, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0};
        exp = '{r3(6,12,18), r3(6,12,18), '0, '0, r3(9,18,27), '0, '0, '0};
        pulse_start();
        wait_done("b2b");
        for (int r = 0; r < 8; r++) begin
            out_addr = 3'(r);
            #1;
            checks++;
            if (out_row !== exp[r]) begin
                errors++;
                $display("FAIL b2b_row%0d: got %h required %h", r, out_row, exp[r]);
            end
        end
    endtask

    task automatic test_timing();
        load_ring();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL timing_busy_rise: got busy=%b done=%b required 1 0", busy, done);
        end
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (coo_address !== 3'(k) || fm_read_addr !== 3'(k) || busy !== 1'b1) begin
                errors++;
                $display("FAIL timing_step%0d: got ca=%0d fa=%0d busy=%b required %0d %0d 1",
                         k, coo_address, fm_read_addr, busy, k, k);
            end
            if (k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || coo_address !== 3'd0) begin
            errors++;
            $display("FAIL timing_drain: got busy=%b done=%b ca=%0d required 1 0 0",
                     busy, done, coo_address);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timing_done8: got done=%b busy=%b required 1 0", done, busy);
        end
        out_addr = 3'd1;
        #1;
        checks++;
        if (out_row !== r3(1, 1, 1)) begin
            errors++;
            $display("FAIL timing_row1: got %h required %h", out_row, r3(1, 1, 1));
        end
        out_addr = 3'd0;
        #1;
        checks++;
        if (out_row !== r3(6, 6, 6)) begin
            errors++;
            $display("FAIL timing_row0: got %h required %h", out_row, r3(6, 6, 6));
        end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 8; i++) begin
            src_m[i] = 3'(i % 6);
            dst_m[i] = 3'd3;
            xw[i]    = x3(1, 0, 2);
        end
        pulse_start();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_done_fall: got done=%b busy=%b required 0 1", done, busy);
        end
        @(negedge clk);
        out_addr = 3'd0;
        #1;
        checks++;
        if (out_row !== '0) begin
            errors++;
            $display("FAIL restart_cleared: got %h required 0", out_row);
        end
        wait_done("restart");
        for (int r = 0; r < 6; r++) begin
            out_addr = 3'(r);
            #1;
            checks++;
            if (out_row !== ((r == 3) ? r3(6, 0, 12) : 57'd0)) begin
                errors++;
                $display("FAIL restart_row%0d: got %h", r, out_row);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            src_m[i] = '0;
            dst_m[i] = '0;
            xw[i]    = '0;
        end
        test_reset();
        test_ring();
        test_reset_mid_pass();
        test_fan_in();
        test_invalid_edge();
        test_back_to_back();
        test_timing();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coo_aggregator.md
COO_AGGREGATOR -- requirements
Module: coo_aggregator

Interface
- REQ-001 Parameter NUM_OF_NODES, default 6: graph node count; the accumulator has one row per node.
- REQ-002 Parameter COO_NUM_OF_COLS, default 6: edge count, one COO column per edge.
- REQ-003 Parameter WEIGHT_COLS, default 3: lanes per feature row.
- REQ-004 Parameter DOT_PROD_WIDTH, default 16: unsigned width of one feature lane.
- REQ-005 Derived NODE_BW = $clog2(NUM_OF_NODES), COO_BW = $clog2(COO_NUM_OF_COLS), AGG_WIDTH = DOT_PROD_WIDTH + $clog2(COO_NUM_OF_COLS+1).
- REQ-006 clk  in  1  single clock; all state is updated on its rising edge.
- REQ-007 reset  in  1  asynchronous, active-low; the block is in reset while reset==0.
- REQ-008 start  in  1  request one aggregation pass.
- REQ-009 coo_address  out  COO_BW  edge index presented to the COO store.
- REQ-010 coo_src  in  NODE_BW  source node of edge coo_address; combinational, same cycle.
- REQ-011 coo_dst  in  NODE_BW  destination node of edge coo_address; combinational, same cycle.
- REQ-012 fm_read_addr  out  NODE_BW  row address into the transformed feature (XW) memory.
- REQ-013 fm_read_row  in  WEIGHT_COLS*DOT_PROD_WIDTH  XW row; valid one cycle after fm_read_addr (synchronous read); lane 0 is in the LSBs.
- REQ-014 busy  out  1  high while a pass is in progress.
- REQ-015 done  out  1  high from pass completion until the next accepted start or reset.
- REQ-016 out_addr  in  NODE_BW  result row select.
- REQ-017 out_row  out  WEIGHT_COLS*AGG_WIDTH  combinational read of accumulator row out_addr; lane 0 is in the LSBs.

Function
- REQ-018 The FSM SHALL have states IDLE, CLEAR, FETCH, DRAIN and DONE.
- REQ-019 IDLE or DONE with start==1 SHALL go to CLEAR; done SHALL fall on the same edge.
- REQ-020 CLEAR SHALL zero all accumulator lanes, set edge_idx=0 and go to FETCH, taking 1 cycle.
- REQ-021 FETCH SHALL drive coo_address=edge_idx and fm_read_addr=coo_src combinationally.
- REQ-022 FETCH SHALL register dst_q<=coo_dst and set vld_q<=1 if coo_src<NUM_OF_NODES and coo_dst<NUM_OF_NODES, else vld_q<=0.
- REQ-023 On every edge where vld_q==1, each lane of acc[dst_q] SHALL be incremented by the corresponding lane of fm_read_row, zero-extended to AGG_WIDTH.
- REQ-024 Edges sharing a destination back-to-back SHALL accumulate correctly; the read-modify-write completes in one cycle and has no hazard.
- REQ-025 In FETCH, edge_idx SHALL increment once per cycle; when edge_idx==COO_NUM_OF_COLS-1 the FSM SHALL go to DRAIN and wrap edge_idx to 0.
- REQ-026 DRAIN SHALL perform the final accumulate, clear vld_q and go to DONE.
- REQ-027 done SHALL be high COO_NUM_OF_COLS+2 edges after the edge that samples start (8 with defaults).
- REQ-028 busy SHALL be 1 exactly in CLEAR, FETCH and DRAIN.
- REQ-029 start while busy SHALL be ignored with no effect on the pass.
- REQ-030 Outside FETCH, coo_address and fm_read_addr SHALL be 0.
- REQ-031 Accumulation SHALL be unsigned modulo 2^AGG_WIDTH; the width rule guarantees no overflow for COO_NUM_OF_COLS edges into one node.
- REQ-032 An out of range out_addr (>=NUM_OF_NODES) SHALL return out_row=0.
- REQ-033 The accumulator contents SHALL be stable in DONE and IDLE.

Reset
- REQ-034 While reset==0, regardless of clock: state=IDLE, edge_idx=0, vld_q=0, dst_q=0, all acc=0, busy=0, done=0, coo_address=0, fm_read_addr=0.
- REQ-035 Reset asserted mid-pass SHALL abort the pass with no partial results retained; after release the block waits in IDLE for start.

Verification
- REQ-036 Reset check: assert reset=0 mid-FETCH -> busy=0, done=0, out_row=0 for every out_addr 0..5.
- REQ-037 Ring graph: edges i: src=i, dst=(i+1)%6; XW row n={n+1,n+1,n+1}; start -> out_row(1)={1,1,1}, out_row(0)={6,6,6}.
- REQ-038 Fan-in: all 6 edges dst=2, src=0..5, every XW lane 0xFFFF -> out_row(2) lanes=393210; all other rows=0.
- REQ-039 Invalid edge: edge 3 src=6, other edges valid -> edge 3 contributes nothing and the other 5 edges accumulate normally.
- REQ-040 Timing: start pulsed 1 cycle -> busy rises on the next edge, coo_address steps 0..5 on consecutive cycles, done=1 exactly 8 edges after start; a second start pulse while busy leaves the result unchanged.
- REQ-041 Restart: start in DONE -> done falls on the next edge, accumulators are cleared, and the new pass result is independent of the previous pass.
